// File: rtl/reg_bank_write_ctrl_pkg.sv
// rtl/reg_bank_write_ctrl_pkg.sv - shared FSM encodings, grant ids and bank defaults
package reg_bank_write_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_bank_write_ctrl_arb.sv
// rtl/reg_bank_write_ctrl_arb.sv - two-way round-robin arbiter, combinational
module arb2_rr
  import reg_bank_write_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // req[0] is requester A, req[1] is requester B; on a tie the side that
  // did not win last time gets the bus.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/reg_bank_write_ctrl.sv
// rtl/reg_bank_write_ctrl.sv - sequences arbitrated writes into a register bank over a shared D bus
module reg_bank_write_ctrl
  import reg_bank_write_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  output logic              b_ack,
  output logic [WIDTH-1:0]  wr_data,
  output logic [NREGS-1:0]  load_n,
  output logic              busy,
  output logic              addr_err
);

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic              gnt_sel, gnt_sel_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [WIDTH-1:0]  wr_data_nxt;
  logic [NREGS-1:0]  load_n_nxt;
  logic [NREGS-1:0]  dec_hit;
  logic              a_ack_nxt, b_ack_nxt, busy_nxt, addr_err_nxt;
  logic [1:0]        grant;
  logic              granted_req;

  arb2_rr u_arb (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // An out-of-range address hits no entry, which is also what flags addr_err.
  for (genvar i = 0; i < NREGS; i++) begin : g_dec
    assign dec_hit[i] = (addr_q == ADDR_W'(i));
  end

  assign granted_req = (gnt_sel == GRANT_A) ? a_req : b_req;

  // Outputs are registered from the current state, so the strobe appears the
  // cycle after LOAD is entered and the ack the cycle after ACK is entered.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_sel_nxt    = gnt_sel;
    addr_nxt       = addr_q;
    wr_data_nxt    = wr_data;
    load_n_nxt     = '1;
    addr_err_nxt   = 1'b0;
    a_ack_nxt      = 1'b0;
    b_ack_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|grant) begin
          gnt_sel_nxt    = grant[1] ? GRANT_B : GRANT_A;
          last_grant_nxt = grant[1] ? GRANT_B : GRANT_A;
          addr_nxt       = grant[1] ? b_addr : a_addr;
          wr_data_nxt    = grant[1] ? b_data : a_data;
          state_nxt      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_n_nxt   = ~dec_hit;
        addr_err_nxt = ~|dec_hit;
        state_nxt    = ST_ACK;
      end
      ST_ACK: begin
        if (granted_req) begin
          a_ack_nxt = (gnt_sel == GRANT_A);
          b_ack_nxt = (gnt_sel == GRANT_B);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_B;
      gnt_sel    <= GRANT_A;
      addr_q     <= '0;
      wr_data    <= '0;
      load_n     <= '1;
      addr_err   <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt_sel    <= gnt_sel_nxt;
      addr_q     <= addr_nxt;
      wr_data    <= wr_data_nxt;
      load_n     <= load_n_nxt;
      addr_err   <= addr_err_nxt;
      a_ack      <= a_ack_nxt;
      b_ack      <= b_ack_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bank_write_ctrl.sv
// tb/tb_reg_bank_write_ctrl.sv - scoreboard bench for reg_bank_write_ctrl
module tb_reg_bank_write_ctrl;

  localparam int WIDTH  = 8;
  localparam int NREGS  = 6;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              a_req = 1'b0, b_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [WIDTH-1:0]  a_data = '0, b_data = '0;
  logic              a_ack, b_ack, busy, addr_err;
  logic [WIDTH-1:0]  wr_data;
  logic [NREGS-1:0]  load_n;

  reg_bank_write_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .wr_data(wr_data), .load_n(load_n), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Register bank model: each entry captures wr_data on a clock edge while its strobe is low.
  logic [WIDTH-1:0] bank_reg [NREGS];
  always @(posedge clk) begin
    for (int i = 0; i < NREGS; i++)
      if (!load_n[i]) bank_reg[i] <= wr_data;
  end

  logic a_s = 1'b0, b_s = 1'b0;
  always @(posedge clk) begin
    a_s <= a_req;
    b_s <= b_req;
  end

  // Scoreboard state: issued requests per side and the expected winner of each grant.
  logic [ADDR_W+WIDTH-1:0] qa[$], qb[$];
  bit                      wq[$];
  bit                      last_win = 1'b1;
  logic [WIDTH-1:0]        exp_bank [NREGS];
  bit                      exp_valid [NREGS];
  bit                      ev_valid = 1'b0;
  int                      ev_cyc = 0;
  int                      cyc = 0;
  logic [NREGS-1:0]        ev_load;
  logic                    ev_err;
  logic [WIDTH-1:0]        ev_data;
  logic                    busy_d = 1'b0, a_ack_d = 1'b0, b_ack_d = 1'b0;

  task automatic on_ack(input bit side);
    logic [ADDR_W+WIDTH-1:0] e;
    logic [ADDR_W-1:0]       ad;
    logic [WIDTH-1:0]        d;
    logic [NREGS-1:0]        el;
    bit                      ok;
    if (wq.size() == 0) chk("grant_seen", 32'd0, 32'd1);
    else chk("winner", 32'(side), 32'(wq.pop_front()));
    if ((side ? qb.size() : qa.size()) == 0) begin
      chk("expected_ack", 32'd0, 32'd1);
      return;
    end
    e  = side ? qb.pop_front() : qa.pop_front();
    ad = e[ADDR_W+WIDTH-1:WIDTH];
    d  = e[WIDTH-1:0];
    el = (int'(ad) < NREGS) ? ~(NREGS'(1) << ad) : '1;
    chk("ack_latency", 32'(ev_valid && (ev_cyc == cyc - 1)), 32'd1);
    chk("load_n", 32'(ev_load), 32'(el));
    chk("addr_err", 32'(ev_err), 32'(int'(ad) >= NREGS));
    chk("wr_data", 32'(ev_data), 32'(d));
    chk("other_ack_low", 32'(side ? a_ack : b_ack), 32'd0);
    if (int'(ad) < NREGS) begin
      exp_bank[ad]  = d;
      exp_valid[ad] = 1'b1;
    end
    ok = 1'b1;
    for (int i = 0; i < NREGS; i++)
      if (exp_valid[i] && bank_reg[i] !== exp_bank[i]) ok = 1'b0;
    chk("bank_contents", 32'(ok), 32'd1);
    ev_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      wq.delete();
      last_win = 1'b1;
      ev_valid = 1'b0;
      busy_d   = 1'b0;
      a_ack_d  = 1'b0;
      b_ack_d  = 1'b0;
    end else begin
      cyc++;
      if (busy && !busy_d) begin
        bit w;
        w = (a_s && b_s) ? !last_win : b_s;
        last_win = w;
        wq.push_back(w);
      end
      if (load_n != '1 || addr_err) begin
        chk("strobe_shape",
            {30'd0, ev_valid && (ev_cyc == cyc - 1),
             ($countones(~load_n) <= 1) && !(load_n != '1 && addr_err)}, 32'd1);
        ev_valid = 1'b1;
        ev_cyc   = cyc;
        ev_load  = load_n;
        ev_err   = addr_err;
        ev_data  = wr_data;
      end
      if (a_ack && !a_ack_d) on_ack(1'b0);
      if (b_ack && !b_ack_d) on_ack(1'b1);
      busy_d  = busy;
      a_ack_d = a_ack;
      b_ack_d = b_ack;
    end
  end

  function automatic logic ack_of(input bit side);
    return side ? b_ack : a_ack;
  endfunction

  task automatic set_side(input bit side, input logic r, input logic [ADDR_W-1:0] ad, input logic [WIDTH-1:0] d);
    if (side) begin b_req = r; b_addr = ad; b_data = d; end
    else      begin a_req = r; a_addr = ad; a_data = d; end
  endtask

  task automatic do_txn(input bit side, input logic [ADDR_W-1:0] ad, input logic [WIDTH-1:0] d,
                        input int delay, input int hold, input bit check_hold, input bit scramble);
    int n;
    repeat (delay) begin @(posedge clk); #1; end
    if (side) qb.push_back({ad, d}); else qa.push_back({ad, d});
    set_side(side, 1'b1, ad, d);
    if (scramble) begin
      @(posedge clk); #1;
      set_side(side, 1'b1, ~ad, ~d);
    end
    n = 0;
    while (!ack_of(side) && n < 100) begin @(posedge clk); #1; n++; end
    chk("ack_arrives", 32'(ack_of(side)), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (check_hold)
        chk("ack_hold", {28'd0, a_ack, b_ack, busy, load_n == '1}, {28'd0, !side, side, 1'b1, 1'b1});
    end
    set_side(side, 1'b0, ADDR_W'($urandom), WIDTH'($urandom));
    n = 0;
    while (ack_of(side) && n < 10) begin @(posedge clk); #1; n++; end
    chk("ack_release", 32'(ack_of(side)), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_n", 32'(load_n), 32'(NREGS'('1)));
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b0, 3'd2, 8'hA5, 0, 0, 1'b0, 1'b0);
    fork
      do_txn(1'b0, 3'd1, 8'h11, 0, 1, 1'b0, 1'b0);
      do_txn(1'b1, 3'd4, 8'h44, 0, 0, 1'b0, 1'b0);
    join
    fork
      do_txn(1'b0, 3'd0, 8'h5A, 0, 0, 1'b0, 1'b0);
      do_txn(1'b1, 3'd5, 8'hC3, 0, 0, 1'b0, 1'b0);
    join
    fork
      do_txn(1'b0, 3'd3, 8'h77, 0, 10, 1'b1, 1'b0);
      do_txn(1'b1, 3'd1, 8'h99, 1, 0, 1'b0, 1'b0);
    join
    do_txn(1'b1, 3'd7, 8'hEE, 0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 3'd3, 8'h3C, 1, 0, 1'b0, 1'b1);

    // Abort during the strobe cycle: the strobe and acks must fall without a clock edge.
    a_req = 1'b1; a_addr = 3'd1; a_data = 8'hF0;
    n = 0;
    while (load_n == '1 && n < 10) begin @(posedge clk); #1; n++; end
    chk("abort_reached_load", 32'(load_n != '1), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_load_n", 32'(load_n), 32'(NREGS'('1)));
    chk("abort_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    a_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fork
      do_txn(1'b0, 3'd4, 8'h12, 0, 0, 1'b0, 1'b0);
      do_txn(1'b1, 3'd2, 8'h34, 0, 0, 1'b0, 1'b0);
    join

    for (int it = 0; it < 40; it++) begin
      fork
        do_txn(1'b0, ADDR_W'($urandom_range(0, 7)), WIDTH'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'b0, 1'b0);
        do_txn(1'b1, ADDR_W'($urandom_range(0, 7)), WIDTH'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'b0, 1'b0);
      join
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queues_drained", 32'(qa.size() + qb.size() + wq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
